instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline: owns the PC, drives the word address into the
//  instruction ROM (combinational read), and registers instruction/PC into the IF/ID register.
//  Handles hazard-unit stalls, EX-stage branch/jump redirects, boot hold-off and fetch faults.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  byte address of the first fetch after reset
//  ROM_AW        12             ROM word-address width (depth = 2**ROM_AW words)
//  BOOT_CYCLES   1              cycles held in BOOT after reset release before first fetch (>=1)
//  NOP_INSN      32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk                          in   1       clock, all state on rising edge
//  rst                          in   1       synchronous, active-high reset
//  instruction_memory_address   out  ROM_AW  word address to ROM = pc[ROM_AW+1:2]
//  instruction_memory_data      in   32      ROM read data, valid same cycle as address
//  stall                        in   1       hazard unit: hold PC and IF/ID
//  redirect_valid               in   1       EX: taken branch / jal / jalr
//  redirect_target              in   32      EX: new PC (byte address)
//  if_id_instruction            out  32      registered instruction to ID
//  if_id_pc                     out  32      registered PC of that instruction
//  if_id_pc_plus4               out  32      registered PC+4 (link value)
//  if_id_valid                  out  1       1 = real instruction, 0 = bubble
//  fetch_fault                  out  1       sticky: misaligned/out-of-range fetch
//  fetch_count                  out  32      instructions captured into IF/ID (wraps)
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_VECTOR, state=BOOT, boot_cnt=0, if_id_instruction=NOP_INSN,
//   if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, fetch_fault=0, fetch_count=0. Reset overrides all.
//  instruction_memory_address = pc[ROM_AW+1:2] in every state (combinational from pc).
//  States: BOOT -> RUN -> FAULT.
//   BOOT: IF/ID holds bubble; boot_cnt++; at boot_cnt==BOOT_CYCLES-1 -> RUN. stall/redirect ignored.
//   RUN, priority redirect > stall > normal, evaluated each edge:
//    redirect_valid: pc<=redirect_target; IF/ID<=bubble (instr NOP_INSN, valid 0, pc fields
//     hold); count unchanged. Redirect wins over simultaneous stall. If target[1:0]!=0 -> FAULT.
//    stall (no redirect): pc and all IF/ID outputs hold; count unchanged.
//    normal: if_id_instruction<=instruction_memory_data, if_id_pc<=pc, if_id_pc_plus4<=pc+4,
//     if_id_valid<=1, pc<=pc+4 (32-bit wrap), fetch_count<=fetch_count+1 (wrap).
//    Range check: if pc[31:ROM_AW+2]!=0 at a normal-fetch edge -> no capture, IF/ID<=bubble, -> FAULT.
//   FAULT: fetch_fault=1, IF/ID bubble, pc frozen; exits only via rst.
//  Latency: ROM word at PC P appears on if_id_* one edge after pc==P in RUN without stall.
//  Throughput: one instruction per cycle; each redirect costs exactly one bubble cycle here.
//  pc+4 arithmetic is modulo 2**32; fetch_count modulo 2**32.
//  Reset asserted mid-stall or mid-redirect: reset state wins on that edge, BOOT restarts.
// TESTING
//  1 Reset, ROM[0..2]=00000293,00128293,00502023, BOOT_CYCLES=1 -> valid low 1 cycle, then
//    if_id (pc,instr)=(0,00000293),(4,00128293),(8,00502023) on consecutive cycles; count=3.
//  2 stall high 2 cycles while pc=8 -> if_id holds (4,00128293), pc stays 8; resumes with (8,...).
//  3 redirect_valid+stall together with target=0 at pc=0x14 -> next cycle valid=0, instr=00000013;
//    following cycle (0,00000293); fetch_count not incremented for bubble.
//  4 redirect target=0x0000_0006 -> fetch_fault=1 next edge, valid stays 0, pc frozen until rst.
//  5 ROM_AW=4, sequential run to pc=0x40 -> fault at that edge, last valid if_id_pc=0x3C.
//  6 rst asserted during stall at pc=0x10 -> next edge pc=RESET_VECTOR, valid=0, count=0, BOOT.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, addresses the instruction ROM
// combinationally and registers instruction/PC/PC+4 into the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ROM_AW       = 12,
  parameter int          BOOT_CYCLES  = 1,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] instruction_memory_address,
  input  logic [31:0]       instruction_memory_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       if_id_instruction,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} state_t;

  localparam int             BCW       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

  state_t         state;
  logic [31:0]    pc;
  logic [BCW-1:0] boot_cnt;
  logic           out_of_range;

  // stall and redirect_valid are level-sensitive requests with no handshake back:
  // they are sampled on every rising edge in RUN, redirect taking priority.
  assign instruction_memory_address = pc[ROM_AW+1:2];
  assign out_of_range               = (pc >> (ROM_AW + 2)) != 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_BOOT;
      pc                <= RESET_VECTOR;
      boot_cnt          <= '0;
      if_id_instruction <= NOP_INSN;
      if_id_pc          <= 32'd0;
      if_id_pc_plus4    <= 32'd0;
      if_id_valid       <= 1'b0;
      fetch_fault       <= 1'b0;
      fetch_count       <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: begin
          boot_cnt <= boot_cnt + BCW'(1);
          if (boot_cnt == BOOT_LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            // Bubble keeps the previous pc fields; only instruction/valid change.
            pc                <= redirect_target;
            if_id_instruction <= NOP_INSN;
            if_id_valid       <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
              state       <= ST_FAULT;
              fetch_fault <= 1'b1;
            end
          end else if (!stall) begin
            if (out_of_range) begin
              if_id_instruction <= NOP_INSN;
              if_id_valid       <= 1'b0;
              state             <= ST_FAULT;
              fetch_fault       <= 1'b1;
            end else begin
              if_id_instruction <= instruction_memory_data;
              if_id_pc          <= pc;
              if_id_pc_plus4    <= pc + 32'd4;
              if_id_valid       <= 1'b1;
              pc                <= pc + 32'd4;
              fetch_count       <= fetch_count + 32'd1;
            end
          end
        end
        ST_FAULT: begin
          if_id_instruction <= NOP_INSN;
          if_id_valid       <= 1'b0;
          fetch_fault       <= 1'b1;
        end
        default: begin
          state       <= ST_FAULT;
          fetch_fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with literal
// expectations, then randomized stall/redirect/reset traffic against a behavioural model.
module tb_instruction_fetch_unit;

  localparam int          ROM_AW   = 4;
  localparam int          ROM_WORDS = 1 << ROM_AW;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ROM_AW-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic [31:0]       if_id_instruction;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_pc_plus4;
  logic              if_id_valid;
  logic              fetch_fault;
  logic [31:0]       fetch_count;

  logic [31:0] rom [ROM_WORDS];
  assign imem_data = rom[imem_addr];

  instruction_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .ROM_AW      (ROM_AW),
    .BOOT_CYCLES (1),
    .NOP_INSN    (NOP)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .instruction_memory_address(imem_addr),
    .instruction_memory_data   (imem_data),
    .stall                     (stall),
    .redirect_valid            (redirect_valid),
    .redirect_target           (redirect_target),
    .if_id_instruction         (if_id_instruction),
    .if_id_pc                  (if_id_pc),
    .if_id_pc_plus4            (if_id_pc_plus4),
    .if_id_valid               (if_id_valid),
    .fetch_fault               (fetch_fault),
    .fetch_count               (fetch_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Holds the architectural view: the PC, how many boot cycles remain, whether the
  // unit is dead, and what IF/ID should present. Updated from the rules directly.
  logic        model_ready = 1'b0;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_count;
  logic        m_valid, m_fault;
  int          m_boot_left;

  always @(posedge clk) begin
    if (rst) begin
      model_ready = 1'b1;
      m_pc = 32'd0; m_boot_left = 1; m_fault = 1'b0;
      m_instr = NOP; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_valid = 1'b0; m_count = 32'd0;
    end else if (model_ready) begin
      if (m_boot_left > 0) begin
        m_boot_left = m_boot_left - 1;
      end else if (m_fault) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (redirect_valid) begin
        m_pc = redirect_target; m_instr = NOP; m_valid = 1'b0;
        if (redirect_target % 4 != 0) m_fault = 1'b1;
      end else if (stall) begin
        // everything holds
      end else if (m_pc >= ROM_BYTES) begin
        m_instr = NOP; m_valid = 1'b0; m_fault = 1'b1;
      end else begin
        m_instr = rom[m_pc / 4]; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
        m_valid = 1'b1; m_pc = m_pc + 4; m_count = m_count + 1;
      end
    end
  end

  // One compare process against the model on every falling edge.
  always @(negedge clk) begin
    if (model_ready) begin
      chk("addr",  32'(imem_addr), (m_pc / 4) % ROM_WORDS);
      chk("instr", if_id_instruction, m_instr);
      chk("if_pc", if_id_pc, m_ifpc);
      chk("if_pc4", if_id_pc_plus4, m_ifpc4);
      chk("valid", 32'(if_id_valid), 32'(m_valid));
      chk("fault", 32'(fetch_fault), 32'(m_fault));
      chk("count", fetch_count, m_count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] t);
    rst = r; stall = s; redirect_valid = rv; redirect_target = t;
  endtask

  task automatic lit_if(input string name, input logic [31:0] pc, input logic [31:0] ins,
                        input logic v);
    chk({name, "_pc"}, if_id_pc, pc);
    chk({name, "_instr"}, if_id_instruction, ins);
    chk({name, "_valid"}, 32'(if_id_valid), 32'(v));
  endtask

  task automatic reset_and_boot();
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rom[0] = 32'h0000_0293;
    rom[1] = 32'h0012_8293;
    rom[2] = 32'h0050_2023;
    for (int i = 3; i < ROM_WORDS; i++) rom[i] = $urandom;

    drive(1'b1, 1'b0, 1'b0, 32'd0);
    cycle();
    cycle();
    lit_if("reset", 32'd0, NOP, 1'b0);
    chk("reset_count", fetch_count, 32'd0);
    chk("reset_fault", 32'(fetch_fault), 32'd0);
    chk("reset_addr", 32'(imem_addr), 32'd0);

    // Sequential fetch after one boot cycle
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    chk("boot_valid", 32'(if_id_valid), 32'd0);
    cycle();
    lit_if("seq0", 32'd0, 32'h0000_0293, 1'b1);
    chk("seq0_pc4", if_id_pc_plus4, 32'd4);
    cycle();
    lit_if("seq1", 32'd4, 32'h0012_8293, 1'b1);

    // Two-cycle stall at pc=8
    stall = 1'b1;
    cycle();
    lit_if("stall1", 32'd4, 32'h0012_8293, 1'b1);
    chk("stall1_addr", 32'(imem_addr), 32'd2);
    cycle();
    lit_if("stall2", 32'd4, 32'h0012_8293, 1'b1);
    stall = 1'b0;
    cycle();
    lit_if("seq2", 32'd8, 32'h0050_2023, 1'b1);
    chk("seq2_count", fetch_count, 32'd3);

    // Redirect together with stall at pc=0x14
    cycle();
    cycle();
    chk("pre_redir_count", fetch_count, 32'd5);
    drive(1'b0, 1'b1, 1'b1, 32'd0);
    cycle();
    lit_if("redir_bubble", 32'h10, NOP, 1'b0);
    chk("redir_count", fetch_count, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    lit_if("redir_tgt", 32'd0, 32'h0000_0293, 1'b1);
    chk("redir_tgt_count", fetch_count, 32'd6);

    // Reset during stall at pc=0x10
    cycle(); cycle(); cycle();
    stall = 1'b1;
    cycle();
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    cycle();
    lit_if("rst_stall", 32'd0, NOP, 1'b0);
    chk("rst_stall_count", fetch_count, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    chk("reboot_valid", 32'(if_id_valid), 32'd0);
    cycle();
    lit_if("reboot_seq0", 32'd0, 32'h0000_0293, 1'b1);

    // Run off the end of a 16-word ROM
    for (int i = 0; i < 15; i++) cycle();
    lit_if("last_word", 32'h3C, rom[15], 1'b1);
    chk("last_fault", 32'(fetch_fault), 32'd0);
    cycle();
    lit_if("range_fault", 32'h3C, NOP, 1'b0);
    chk("range_fault_flag", 32'(fetch_fault), 32'd1);
    chk("range_count", fetch_count, 32'd16);

    // Misaligned redirect target
    reset_and_boot();
    cycle();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0006);
    cycle();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_valid", 32'(if_id_valid), 32'd0);
    chk("mis_addr", 32'(imem_addr), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0020);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(); cycle();
    chk("mis_frozen_addr", 32'(imem_addr), 32'd1);
    chk("mis_sticky", 32'(fetch_fault), 32'd1);

    // Randomized traffic
    reset_and_boot();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      tgt = 32'($urandom_range(0, 20)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, tgt);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
